key_debounce: RTL and testbench

Debounces one mechanical push-button and turns it into clean, single-cycle press, release and long-press events plus a press-toggled level. It sits between the board key pin and the LED and timer logic. It is the input-side counterpart to the LED blinker: it reads the human-facing pin instead of driving it. It is clocked from the 50 MHz system clock and uses no other clock.

---
 rtl/key_debounce.sv | 137 +++++++++++++
 tb/tb_key_debounce.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer, press/release filter FSM,
// one-cycle press/release/long-press pulses and a press-toggled level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_toggle
);

    localparam logic [25:0] DEB_LAST  = 26'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        REL_FILT
    } state_t;

    state_t      state, state_nx;
    logic        sync_q1, key_s;
    logic [25:0] filt_cnt, filt_nx;
    logic [25:0] hold_cnt, hold_nx;
    logic        long_done, long_done_nx;
    logic        key_state_nx, key_press_nx, key_release_nx;
    logic        key_long_nx, key_toggle_nx;

    // Bring the raw pin into the clock domain; idle level is released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= 1'b1;
            key_s   <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            key_s   <= sync_q1;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_toggle  <= 1'b0;
        end else begin
            state       <= state_nx;
            filt_cnt    <= filt_nx;
            hold_cnt    <= hold_nx;
            long_done   <= long_done_nx;
            key_state   <= key_state_nx;
            key_press   <= key_press_nx;
            key_release <= key_release_nx;
            key_long    <= key_long_nx;
            key_toggle  <= key_toggle_nx;
        end
    end

    // Next-state logic: filter level changes, time the hold, form pulses.
    always_comb begin
        state_nx       = state;
        filt_nx        = filt_cnt;
        hold_nx        = hold_cnt;
        long_done_nx   = long_done;
        key_state_nx   = key_state;
        key_press_nx   = 1'b0;
        key_release_nx = 1'b0;
        key_long_nx    = 1'b0;
        key_toggle_nx  = key_toggle;
        unique case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nx = PRESS_FILT;
                    filt_nx  = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_nx = IDLE;
                    filt_nx  = '0;
                end else if (filt_cnt == DEB_LAST) begin
                    state_nx      = DOWN;
                    filt_nx       = '0;
                    hold_nx       = '0;
                    key_press_nx  = 1'b1;
                    key_state_nx  = 1'b1;
                    key_toggle_nx = ~key_toggle;
                end else begin
                    filt_nx = filt_cnt + 26'd1;
                end
            end
            DOWN: begin
                if (hold_cnt != LONG_LAST) begin
                    hold_nx = hold_cnt + 26'd1;
                end else if (!long_done) begin
                    key_long_nx  = 1'b1;
                    long_done_nx = 1'b1;
                end
                if (key_s) begin
                    state_nx = REL_FILT;
                    filt_nx  = '0;
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    state_nx = DOWN;
                    filt_nx  = '0;
                end else if (filt_cnt == DEB_LAST) begin
                    state_nx       = IDLE;
                    filt_nx        = '0;
                    key_release_nx = 1'b1;
                    key_state_nx   = 1'b0;
                    long_done_nx   = 1'b0;
                end else begin
                    filt_nx = filt_cnt + 26'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                filt_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: expected pulse times are queued when the key is
// driven and matched against observed pulses; levels checked from a table.
module tb_key_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_n;
    logic key_state, key_press, key_release, key_long, key_toggle;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef enum int {EV_PRESS, EV_REL, EV_LONG} ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
    } ev_t;

    typedef struct {
        int hold;
        bit exp_long;
        bit exp_tog;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[5];

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_n(key_n),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .key_toggle(key_toggle)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic push(input ev_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic got(input ev_e k);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s at cyc %0d: got pulse expected none",
                     k.name(), cyc);
        end else begin
            e = sb.pop_front();
            chk("event_kind", int'(k), int'(e.kind));
            chk($sformatf("%s_cycle", e.kind.name()), cyc, e.cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic int outs();
        return int'({key_state, key_press, key_release, key_long, key_toggle});
    endfunction

    // Scoreboard monitor: flag missed expectations, then match pulses.
    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_%s: got none expected pulse at cyc %0d",
                     sb[0].kind.name(), sb[0].cyc);
            void'(sb.pop_front());
        end
        if (key_press)   got(EV_PRESS);
        if (key_release) got(EV_REL);
        if (key_long)    got(EV_LONG);
    end

    initial begin
        int c;
        vecs[0] = '{hold: 10, exp_long: 1'b0, exp_tog: 1'b1};
        vecs[1] = '{hold: 60, exp_long: 1'b1, exp_tog: 1'b0};
        vecs[2] = '{hold: 24, exp_long: 1'b1, exp_tog: 1'b1};
        vecs[3] = '{hold: 23, exp_long: 1'b0, exp_tog: 1'b0};
        vecs[4] = '{hold: 5,  exp_long: 1'b0, exp_tog: 1'b1};

        sys_rst_n = 1'b0;
        key_n     = 1'b1;

        // Reset held while the pin toggles.
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            key_n = ~key_n;
            chk("reset_outputs", outs(), 0);
        end
        @(negedge sys_clk);
        key_n     = 1'b1;
        sys_rst_n = 1'b1;
        tick(100);
        chk("idle_outputs", outs(), 0);

        // Clean presses of varying length.
        for (int i = 0; i < 5; i++) begin
            c = cyc;
            key_n = 1'b0;
            push(EV_PRESS, c + 3 + D);
            if (vecs[i].exp_long) push(EV_LONG, c + 3 + D + L);
            tick(vecs[i].hold);
            if (vecs[i].hold >= 8) begin
                chk($sformatf("vec%0d_state_held", i), int'(key_state), 1);
                chk($sformatf("vec%0d_toggle_held", i), int'(key_toggle),
                    int'(vecs[i].exp_tog));
            end
            key_n = 1'b1;
            push(EV_REL, cyc + 3 + D);
            tick(12);
            chk($sformatf("vec%0d_state_rel", i), int'(key_state), 0);
            chk($sformatf("vec%0d_toggle_rel", i), int'(key_toggle),
                int'(vecs[i].exp_tog));
            chk($sformatf("vec%0d_pending", i), sb.size(), 0);
        end

        // Bounce on press: only the last 1->0 edge counts.
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        push(EV_PRESS, cyc + 3 + D);
        tick(15);
        chk("bounce_state", int'(key_state), 1);
        chk("bounce_toggle", int'(key_toggle), 0);
        key_n = 1'b1;
        push(EV_REL, cyc + 3 + D);
        tick(12);
        chk("bounce_state_rel", int'(key_state), 0);
        chk("bounce_pending", sb.size(), 0);

        // Two-cycle glitch mid-hold: two frozen cycles delay key_long.
        c = cyc;
        key_n = 1'b0;
        push(EV_PRESS, c + 3 + D);
        push(EV_LONG, c + 3 + D + L + 2);
        tick(12);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(26);
        chk("glitch_state", int'(key_state), 1);
        chk("glitch_toggle", int'(key_toggle), 1);
        key_n = 1'b1;
        push(EV_REL, cyc + 3 + D);
        tick(12);
        chk("glitch_state_rel", int'(key_state), 0);
        chk("glitch_toggle_rel", int'(key_toggle), 1);
        chk("glitch_pending", sb.size(), 0);

        // Reset while held down; press is re-filtered afterwards.
        c = cyc;
        key_n = 1'b0;
        push(EV_PRESS, c + 3 + D);
        tick(15);
        chk("midrst_state_before", int'(key_state), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_outputs", outs(), 0);
        tick(3);
        sys_rst_n = 1'b1;
        push(EV_PRESS, cyc + 3 + D);
        tick(10);
        chk("midrst_state_after", int'(key_state), 1);
        chk("midrst_toggle_after", int'(key_toggle), 1);
        key_n = 1'b1;
        push(EV_REL, cyc + 3 + D);
        tick(12);
        chk("midrst_state_rel", int'(key_state), 0);
        chk("midrst_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
